// File: rtl/if_prefetch_queue_if.sv
// Bus bundle for the instruction prefetch queue: imem fetch port, decode
// redirect/stall inputs and the IF/ID-facing instruction output.
interface if_prefetch_queue_if #(
  parameter int AW = 2
) ();
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic [31:0] out_inst;
  logic [31:0] out_pc4;
  logic [AW:0] count;

  modport slave (
    input  redirect, redirect_pc, id_stall, imem_ack, imem_rdata,
    output imem_req, imem_addr, out_valid, out_inst, out_pc4, count
  );

  modport master (
    output redirect, redirect_pc, id_stall, imem_ack, imem_rdata,
    input  imem_req, imem_addr, out_valid, out_inst, out_pc4, count
  );
endinterface

// File: rtl/if_prefetch_queue.sv
// Sequential instruction prefetch FIFO between imem and IF/ID.
// Optional PFQ_BYPASS_EN: present an acked word in its ack cycle when the FIFO is empty.
//
// state  | meaning
// S_IDLE | no request outstanding; issue when space remains and no redirect
// S_WAIT | request at r_req_addr outstanding; push on ack
// S_DROP | request killed by a redirect; discard the ack, then go idle
module if_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter int          AW       = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  if_prefetch_queue_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_req_addr;
  logic [31:0]   r_fifo_inst [DEPTH];
  logic [31:0]   r_fifo_pc4  [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count;

  logic [AW:0]   w_count_nxt;
  logic [31:0]   w_fetch_pc4, w_head_inst, w_head_pc4;
  logic          w_empty, w_ack_live, w_bypass, w_out_valid;
  logic          w_pop, w_push, w_space;

  assign w_empty     = (r_count == '0);
  assign w_fetch_pc4 = r_fetch_pc + 32'd4;
  // A redirect outranks the ack, so a same-cycle ack never counts as live.
  assign w_ack_live  = bus.imem_ack && (r_state == S_WAIT) && !bus.redirect;

`ifdef PFQ_BYPASS_EN
  assign w_bypass    = w_empty && w_ack_live;
  assign w_head_inst = w_empty ? bus.imem_rdata : r_fifo_inst[r_rd_ptr];
  assign w_head_pc4  = w_empty ? w_fetch_pc4    : r_fifo_pc4[r_rd_ptr];
`else
  assign w_bypass    = 1'b0;
  assign w_head_inst = r_fifo_inst[r_rd_ptr];
  assign w_head_pc4  = r_fifo_pc4[r_rd_ptr];
`endif

  assign w_out_valid = !bus.redirect && (!w_empty || w_bypass);
  assign w_pop       = w_out_valid && !bus.id_stall && !w_empty;
  assign w_push      = w_ack_live && !(w_bypass && !bus.id_stall);
  assign w_count_nxt = r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
  assign w_space     = (w_count_nxt < (AW+1)'(DEPTH));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (!bus.redirect && w_space) w_state_nxt = S_WAIT;
      S_WAIT: begin
        // Redirect with a same-cycle ack has nothing left in flight to drop.
        if (bus.redirect)       w_state_nxt = bus.imem_ack ? S_IDLE : S_DROP;
        else if (bus.imem_ack)  w_state_nxt = w_space ? S_WAIT : S_IDLE;
      end
      S_DROP: if (bus.imem_ack) w_state_nxt = S_IDLE;
      default:                  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= RESET_PC;
      r_req_addr <= RESET_PC;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (bus.redirect)    r_fetch_pc <= bus.redirect_pc;
      else if (w_ack_live) r_fetch_pc <= w_fetch_pc4;
      if (w_state_nxt == S_WAIT) r_req_addr <= w_ack_live ? w_fetch_pc4 : r_fetch_pc;
      if (bus.redirect) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
        r_count <= w_count_nxt;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_fifo_inst[r_wr_ptr] <= bus.imem_rdata;
      r_fifo_pc4[r_wr_ptr]  <= w_fetch_pc4;
    end
  end

  assign bus.imem_req  = (r_state != S_IDLE);
  assign bus.imem_addr = r_req_addr;
  assign bus.out_valid = w_out_valid;
  assign bus.out_inst  = w_out_valid ? w_head_inst : 32'h0;
  assign bus.out_pc4   = w_out_valid ? w_head_pc4  : 32'h0;
  assign bus.count     = r_count;

endmodule
